// File: rtl/jk_pkg.sv
// jk_pkg: definitions shared by the JK modulo counter and its cells.
//   JK_* : 2-bit {J,K} command encodings driven into each jk_cell
//   min_width() : smallest register width able to hold 0..modulus-1
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Always at least one bit, so a modulus of 2 needs a 1-bit register.
  function automatic int min_width(input int modulus);
    int w;
    w = 1;
    while ((1 << w) < modulus) w++;
    return w;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell: a single JK flip-flop with synchronous active-low reset.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low; clears q
//   j, k  - JK command: 00 hold, 01 clear, 10 set, 11 toggle
//   q     - stored bit
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  // Next-state table of a JK flip-flop.
  always_comb begin
    q_d = q_q;
    case ({j, k})
      JK_HOLD:   q_d = q_q;
      JK_RESET:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
      default:   q_d = q_q;
    endcase
  end

  // Reset is sampled on the clock edge and wins over any JK command.
  always_ff @(posedge clk) begin
    if (!reset) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: up/down modulo-MODULUS counter built from JK flip-flops.
// Parameters:
//   WIDTH   - counter width in bits
//   MODULUS - count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous, active-low; clears count and pulses
//   en       - count enable
//   up       - direction, 1 = up, 0 = down
//   load     - parallel-load request (beats en)
//   d        - parallel-load value
//   q        - current count
//   tc       - combinational terminal count for cascading
//   wrap     - registered one-cycle pulse after a wrap-around
//   load_err - registered one-cycle pulse after an out-of-range load
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Refuse to build a counter that cannot represent its own range.
  if (MODULUS < 2 || MODULUS > (1 << WIDTH) || min_width(MODULUS) > WIDTH) begin : g_bad_params
    $error("jk_mod_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             load_ok;
  logic             wrap_q;
  logic             wrap_d;
  logic             load_err_q;
  logic             load_err_d;

  // The extra top bit lets a full-range modulus (2**WIDTH) compare without overflow.
  assign load_ok = ({1'b0, d} < (WIDTH + 1)'(MODULUS));

  // Pick the next count, then translate it into per-bit JK commands.
  // Counting toggles exactly the bits that differ between now and next;
  // an out-of-range count is treated as terminal so the counter recovers.
  always_comb begin
    count_nxt  = count;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    j_vec      = '0;
    k_vec      = '0;
    if (load) begin
      if (load_ok) begin
        j_vec = d;
        k_vec = ~d;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (count >= MAX_COUNT) begin
          count_nxt = '0;
          wrap_d    = 1'b1;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0 || count > MAX_COUNT) begin
          count_nxt = MAX_COUNT;
          wrap_d    = 1'b1;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
      j_vec = count_nxt ^ count;
      k_vec = count_nxt ^ count;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j_vec[i]),
      .k     (k_vec[i]),
      .q     (count[i])
    );
  end

  // Status pulses; reset drops any pulse that would have been raised this edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = count;
  assign tc       = en & ((up & (count == MAX_COUNT)) | (~up & (count == '0)));
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule
